load_store_unit: RTL

- Sits between the core's execute/memory stage and the DE1-SoC memory_map block.
- Takes one RV32I load or store request at a time and generates the aligned word address, byte-lane write enables and lane-replicated write data for memory_map.
- Absorbs memory_map's registered read latency.
- Returns sign- or zero-extended load data plus misalignment and illegal-funct3 status through a single-pulse response.

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of the DE1-SoC memory_map block: aligns addresses,
// builds byte-lane strobes/data, waits out the read latency and returns extended load data.
module load_store_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT, S_RESP} state_e;

  // Returns {illegal, misaligned}; illegal wins, so misaligned is cleared when illegal.
  function automatic logic [1:0] classify(input logic wr, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic ill, mis;
    ill = wr ? !(f3 inside {3'b000, 3'b001, 3'b010})
             : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return {ill, mis & ~ill};
  endfunction

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;

  logic [1:0]  req_class, lat_class;
  logic [3:0]  req_mask;
  logic [31:0] req_lanes;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign req_class = classify(req_write, req_funct3, req_addr[1:0]);
  assign lat_class = classify(write_q, funct3_q, off_q);
  assign shifted   = mem_read_data >> {off_q, 3'b000};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_mask  = 4'b1111;
    req_lanes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_mask  = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_mask  = 4'b0011 << req_addr[1:0];
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    ill_d    = ill_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        write_d  = req_write;
        funct3_d = req_funct3;
        off_d    = req_addr[1:0];
        rdata_d  = '0;
        mis_d    = 1'b0;
        ill_d    = 1'b0;
        if (req_class != 2'b00) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_ISSUE;
          addr_d  = {req_addr[31:2], 2'b00};
          mask_d  = req_mask;
          if (req_write) wdata_d = req_lanes;
        end
      end
      S_ISSUE: begin
        state_d = write_q ? S_RESP : S_WAIT;
        cnt_d   = 2'(READ_LATENCY - 1);
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_FAULT: begin
        ill_d   = lat_class[1];
        mis_d   = lat_class[0];
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, sampled at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      cnt_q    <= 2'd0;
      mask_q   <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = (state_q == S_RESP);
  assign resp_rdata       = rdata_q;
  assign resp_misaligned  = mis_q;
  assign resp_illegal     = ill_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = (state_q == S_ISSUE && write_q) ? mask_q : 4'b0000;

endmodule
